// File: rtl/fifo_fwft_flags.sv
// fifo_fwft_flags: synchronous first-word-fall-through FIFO with valid/ready
// handshakes on both sides. It uses all 2**ADDR_WIDTH entries and has runtime
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional feature: define FIFO_WATERMARK_EN to make max_count track peak
// occupancy. Without the macro, max_count is tied to zero.
//
// Read side: RAM sync read (p0) -> prefetch register (p1) -> output register (p2).
// {vld_p2, vld_p1} encodes the pipeline state:
//   00 = EMPTY, 10 = ONE, 11 = PRIMED.
// A RAM read is issued only when the landing word is sure to find a free
// register next cycle, so no more than two words ever sit in p1/p2.
module fifo_fwft_flags #(
  parameter int DWIDTH      = 20,
  parameter int ADDR_WIDTH  = 6,
  parameter int COUNT_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DWIDTH-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DWIDTH-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic [COUNT_WIDTH-1:0] af_thresh,
  input  logic [COUNT_WIDTH-1:0] ae_thresh,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [COUNT_WIDTH-1:0] data_count,
  output logic                   overflow_err,
  output logic                   underflow_err,
  input  logic                   err_clr,
  output logic [COUNT_WIDTH-1:0] max_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(DEPTH);

  logic [DWIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [COUNT_WIDTH-1:0] count, ram_cnt;
  logic [DWIDTH-1:0]      rd_data_p0, pf_data_p1, out_data_p2;
  logic                   vld_p0, vld_p1, vld_p2;

  logic                   wr_acc, rd_acc, keep_out;
  logic                   wr_direct, wr_ram, rd_issue;
  logic [1:0]             n_keep, n_next;
  logic [DWIDTH-1:0]      out_d, pf_d;
  logic                   out_v_d, pf_v_d;
  logic                   ovf_flag, udf_flag;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign in_ready     = ~full;
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);
  assign data_count   = count;
  assign out_data     = out_data_p2;
  assign out_valid    = vld_p2;
  assign overflow_err  = ovf_flag;
  assign underflow_err = udf_flag;

  // Handshake decode and routing of each word: bypass to registers or park in RAM.
  always_comb begin
    wr_acc    = in_valid & ~full;
    rd_acc    = vld_p2 & out_ready;
    keep_out  = vld_p2 & ~rd_acc;
    n_keep    = 2'(keep_out) + 2'(vld_p1) + 2'(vld_p0);
    wr_direct = wr_acc & (ram_cnt == '0) & (n_keep < 2'd2);
    wr_ram    = wr_acc & ~wr_direct;
    n_next    = n_keep + 2'(wr_direct);
    rd_issue  = (ram_cnt != '0) & (n_next <= 2'd1);
  end

  // Fill output and prefetch registers with the oldest available words in order.
  always_comb begin
    out_d   = out_data_p2;
    out_v_d = keep_out;
    pf_d    = pf_data_p1;
    pf_v_d  = 1'b0;
    if (keep_out) begin
      if (vld_p1) begin
        pf_v_d = 1'b1;
        pf_d   = pf_data_p1;
      end else if (vld_p0) begin
        pf_v_d = 1'b1;
        pf_d   = rd_data_p0;
      end else if (wr_direct) begin
        pf_v_d = 1'b1;
        pf_d   = in_data;
      end
    end else begin
      if (vld_p1) begin
        out_v_d = 1'b1;
        out_d   = pf_data_p1;
        if (vld_p0) begin
          pf_v_d = 1'b1;
          pf_d   = rd_data_p0;
        end else if (wr_direct) begin
          pf_v_d = 1'b1;
          pf_d   = in_data;
        end
      end else if (vld_p0) begin
        out_v_d = 1'b1;
        out_d   = rd_data_p0;
        if (wr_direct) begin
          pf_v_d = 1'b1;
          pf_d   = in_data;
        end
      end else if (wr_direct) begin
        out_v_d = 1'b1;
        out_d   = in_data;
      end
    end
  end

  // Block-RAM storage: write port plus registered read port (stage p0).
  always_ff @(posedge clk) begin
    if (wr_ram) mem[wr_ptr] <= in_data;
    if (rd_issue) rd_data_p0 <= mem[rd_ptr];
  end

  // Data registers of stages p1/p2; contents are don't-care while invalid.
  always_ff @(posedge clk) begin
    pf_data_p1  <= pf_d;
    out_data_p2 <= out_d;
  end

  // Control state: valids, pointers, RAM occupancy and total occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      count   <= '0;
    end else begin
      vld_p0  <= rd_issue;
      vld_p1  <= pf_v_d;
      vld_p2  <= out_v_d;
      if (wr_ram) wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      ram_cnt <= ram_cnt + COUNT_WIDTH'(wr_ram) - COUNT_WIDTH'(rd_issue);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag <= 1'b0;
      udf_flag <= 1'b0;
    end else begin
      if (in_valid & full) ovf_flag <= 1'b1;
      else if (err_clr)    ovf_flag <= 1'b0;
      if (out_ready & ~vld_p2) udf_flag <= 1'b1;
      else if (err_clr)        udf_flag <= 1'b0;
    end
  end

`ifdef FIFO_WATERMARK_EN
  logic [COUNT_WIDTH-1:0] max_q;

  // Peak occupancy since reset, restarted from the current count by err_clr.
  always_ff @(posedge clk) begin
    if (rst)                max_q <= '0;
    else if (err_clr)       max_q <= count;
    else if (count > max_q) max_q <= count;
  end

  assign max_count = max_q;
`else
  assign max_count = '0;
`endif

endmodule

// File: tb/tb_fifo_fwft_flags.sv
// Testbench for fifo_fwft_flags (ADDR_WIDTH=4, DEPTH=16).
// A negedge monitor keeps an independent occupancy model and a data scoreboard.
// Scenario tasks drive stimulus and check flags inline.
module tb_fifo_fwft_flags;

  localparam int DW = 20;
  localparam int AW = 4;
  localparam int CW = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk, rst;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready;
  logic [CW-1:0] af_thresh, ae_thresh;
  logic          full, empty, almost_full, almost_empty;
  logic [CW-1:0] data_count;
  logic          overflow_err, underflow_err, err_clr;
  logic [CW-1:0] max_count;

  int checks = 0;
  int passes = 0;
  int nreads = 0;
  int model_cnt = 0;
  logic [DW-1:0] sb[$];

  fifo_fwft_flags #(.DWIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .data_count(data_count),
    .overflow_err(overflow_err), .underflow_err(underflow_err), .err_clr(err_clr),
    .max_count(max_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: at the negedge, model which transfers the coming edge accepts.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      model_cnt = 0;
    end else begin
      checks++;
      if (data_count !== CW'(model_cnt))
        $display("FAIL count: got %0d expected %0d", data_count, model_cnt);
      else passes++;
      checks++;
      if (out_valid !== (model_cnt != 0))
        $display("FAIL out_valid: got %0b expected %0b", out_valid, model_cnt != 0);
      else passes++;
      if (out_ready && model_cnt != 0) begin
        logic [DW-1:0] exp;
        exp = sb.pop_front();
        nreads++;
        checks++;
        if (out_data !== exp)
          $display("FAIL data: got %0h expected %0h", out_data, exp);
        else passes++;
      end
      if (in_valid && model_cnt != DEPTH) sb.push_back(in_data);
      model_cnt = model_cnt + ((in_valid && model_cnt != DEPTH) ? 1 : 0)
                            - ((out_ready && model_cnt != 0) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 40) begin
      out_ready = 1'b1;
      tick();
      n++;
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid) $display("FAIL drain_timeout: got out_valid=%0b expected 0", out_valid);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b expected 0", out_valid); else passes++;
    checks++; if (empty !== 1'b1) $display("FAIL rst_empty: got %0b expected 1", empty); else passes++;
    checks++; if (full !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_full_ready: got %0b/%0b expected 0/1", full, in_ready); else passes++;
    checks++; if (data_count !== '0) $display("FAIL rst_count: got %0d expected 0", data_count); else passes++;
    checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) $display("FAIL rst_err: got %0b%0b expected 00", overflow_err, underflow_err); else passes++;
    checks++; if (max_count !== '0) $display("FAIL rst_max: got %0d expected 0", max_count); else passes++;
  endtask

  task automatic test_fwft();
    in_data = 20'h00001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("FAIL fwft_valid: got %0b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 20'h00001) $display("FAIL fwft_data: got %0h expected 1", out_data); else passes++;
    checks++; if (data_count !== 5'd1 || empty !== 1'b0) $display("FAIL fwft_count: got %0d/%0b expected 1/0", data_count, empty); else passes++;
    drain();
  endtask

  task automatic test_full();
    int r0;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = DW'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (full !== 1'b1 || in_ready !== 1'b0) $display("FAIL full_flags: got %0b/%0b expected 1/0", full, in_ready); else passes++;
    checks++; if (data_count !== 5'd16) $display("FAIL full_count: got %0d expected 16", data_count); else passes++;
    in_data = 20'h00099;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (overflow_err !== 1'b1) $display("FAIL overflow: got %0b expected 1", overflow_err); else passes++;
    checks++; if (data_count !== 5'd16) $display("FAIL ovf_count: got %0d expected 16", data_count); else passes++;
    r0 = nreads;
    drain();
    checks++; if (nreads - r0 != DEPTH) $display("FAIL full_readback: got %0d expected %0d", nreads - r0, DEPTH); else passes++;
    checks++; if (empty !== 1'b1 || underflow_err !== 1'b0) $display("FAIL full_empty: got %0b/%0b expected 1/0", empty, underflow_err); else passes++;
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (underflow_err !== 1'b1) $display("FAIL underflow: got %0b expected 1", underflow_err); else passes++;
    checks++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky: got %0b expected 1", overflow_err); else passes++;
    checks++; if (data_count !== '0 || out_valid !== 1'b0) $display("FAIL udf_state: got %0d/%0b expected 0/0", data_count, out_valid); else passes++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) $display("FAIL err_clr: got %0b%0b expected 00", overflow_err, underflow_err); else passes++;
    out_ready = 1'b1;
    err_clr = 1'b1;
    tick();
    out_ready = 1'b0;
    err_clr = 1'b0;
    checks++; if (underflow_err !== 1'b1) $display("FAIL clr_vs_event: got %0b expected 1", underflow_err); else passes++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (underflow_err !== 1'b0) $display("FAIL err_clr2: got %0b expected 0", underflow_err); else passes++;
  endtask

  task automatic test_thresholds();
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    for (int k = 0; k <= DEPTH; k++) begin
      checks++;
      if (almost_empty !== (k <= 3)) $display("FAIL almost_empty@%0d: got %0b expected %0b", k, almost_empty, k <= 3);
      else passes++;
      checks++;
      if (almost_full !== (k >= 12)) $display("FAIL almost_full@%0d: got %0b expected %0b", k, almost_full, k >= 12);
      else passes++;
      if (k < DEPTH) begin
        in_data = DW'(20'h300 + k);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
      end
    end
    af_thresh = 5'd17;
    #1;
    checks++; if (almost_full !== 1'b0 || full !== 1'b1) $display("FAIL af_above_depth: got %0b/%0b expected 0/1", almost_full, full); else passes++;
    af_thresh = 5'd16;
    #1;
    checks++; if (almost_full !== 1'b1) $display("FAIL af_eq_depth: got %0b expected 1", almost_full); else passes++;
    drain();
  endtask

  task automatic test_back_to_back();
    int r0;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'(20'h400 + i);
      in_valid = 1'b1;
      tick();
    end
    r0 = nreads;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = DW'(20'h500 + i);
      tick();
      checks++;
      if (data_count !== 5'd3) $display("FAIL b2b_count@%0d: got %0d expected 3", i, data_count);
      else passes++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (nreads - r0 != 100) $display("FAIL b2b_rate: got %0d expected 100", nreads - r0); else passes++;
    drain();
  endtask

  task automatic test_one_word();
    in_data = 20'h000A0;
    in_valid = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = DW'(20'h200 + i);
      tick();
      checks++;
      if (out_data !== DW'(20'h200 + i) || data_count !== 5'd1)
        $display("FAIL one_word@%0d: got %0h/%0d expected %0h/1", i, out_data, data_count, 20'h200 + i);
      else passes++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_data = DW'($urandom);
      in_valid = !full && ($urandom_range(0, 3) != 0);
      out_ready = out_valid && ($urandom_range(0, 2) == 0 || i > 200);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    drain();
    checks++; if (sb.size() != 0) $display("FAIL random_leftover: got %0d expected 0", sb.size()); else passes++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      in_data = DW'(20'h600 + i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (data_count !== 5'd5) $display("FAIL mid_count: got %0d expected 5", data_count); else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0) $display("FAIL mid_reset: got %0b/%0b expected 1/0", empty, out_valid); else passes++;
  endtask

  task automatic test_watermark();
    for (int i = 0; i < 9; i++) begin
      in_data = DW'(20'h700 + i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    out_ready = 1'b0;
    tick();
    checks++; if (data_count !== 5'd2) $display("FAIL wm_count: got %0d expected 2", data_count); else passes++;
`ifdef FIFO_WATERMARK_EN
    checks++; if (max_count !== 5'd9) $display("FAIL wm_peak: got %0d expected 9", max_count); else passes++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (max_count !== 5'd2) $display("FAIL wm_clr: got %0d expected 2", max_count); else passes++;
`else
    checks++; if (max_count !== '0) $display("FAIL wm_off: got %0d expected 0", max_count); else passes++;
`endif
    drain();
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    err_clr = 1'b0;
    af_thresh = 5'd16;
    ae_thresh = 5'd0;
    test_reset();
    test_fwft();
    test_full();
    test_errors();
    test_thresholds();
    test_back_to_back();
    test_one_word();
    test_random();
    test_reset_mid();
    test_watermark();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_fwft_flags.md
Name: fifo_fwft_flags

Overview:
- Parametrised synchronous FIFO.
- Successor to the basic block-RAM queue: first-word-fall-through (FWFT) output with a valid/ready handshake on both sides.
- Uses all 2**ADDR_WIDTH entries (no sacrificed slot), has runtime almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Sits between producer and consumer pipeline stages in the same clock domain.

Parameters:
- DWIDTH, 20, data word width in bits.
- ADDR_WIDTH, 6, log2 of storage depth; DEPTH = 2**ADDR_WIDTH entries, block-RAM style storage.
- COUNT_WIDTH, ADDR_WIDTH+1, width of occupancy outputs; must hold 0..DEPTH inclusive.

Ports:
- clk  in  1  rising-edge clock, sole clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DWIDTH  write data.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  FIFO can accept; equals ~full.
- out_data  out  DWIDTH  head word, valid when out_valid=1.
- out_valid  out  1  head word present (FWFT).
- out_ready  in  1  consumer takes head word.
- af_thresh  in  COUNT_WIDTH  almost-full threshold, sampled every cycle.
- ae_thresh  in  COUNT_WIDTH  almost-empty threshold, sampled every cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- data_count  out  COUNT_WIDTH  entries held, including the output register.
- overflow_err  out  1  sticky: in_valid seen while full.
- underflow_err  out  1  sticky: out_ready seen while ~out_valid.
- err_clr  in  1  clears both sticky flags.
- max_count  out  COUNT_WIDTH  peak occupancy (optional feature).

Behaviour:
- Only clock is clk; reset is synchronous, active-high, named rst.
- Reset values: count=0, pointers=0, out_valid=0, empty=1, full=0, in_ready=1, both error flags=0, max_count=0. out_data is don't-care.
- Reset mid-operation discards all contents; out_valid drops the cycle after rst is sampled.

Accept rules:
- Write accepted when in_valid & in_ready.
- Read accepted when out_valid & out_ready.
- in_ready depends only on registered state: no combinational path from out_ready.

Count and flags:
- data_count increments on write-only, decrements on read-only, and is unchanged on simultaneous write+read.
- Count never wraps.
- full, empty, almost_full and almost_empty are combinational from the registered count and live thresholds.

FWFT latency:
- A write accepted at cycle t into an empty FIFO gives out_valid=1 and out_data=that word at t+1, via a bypass into the output register.
- Sustained throughput is 1 word/cycle in and out.

Output pipeline:
- Output register plus one prefetch register in front of the synchronous RAM read.
- Three states:
  - EMPTY: no valid data.
  - ONE: output register valid, prefetch invalid.
  - PRIMED: output and prefetch valid, RAM may hold more.
- Read in PRIMED: prefetch moves to the output register, and a RAM read is issued for the next word if the RAM holds one.
- Write when the RAM holds nothing and prefetch is empty: goes directly to the prefetch register (or to the output register if it is empty).
- Data order strictly preserved under every write/read combination.

Boundaries:
- Simultaneous write+read when count==1: output register replaced by the new word the next cycle.
- Write while full: ignored, data dropped, overflow_err set the next cycle.
- out_ready while empty: no state change, underflow_err set.
- Pointers wrap modulo DEPTH.

Error flags:
- Stay set until rst or err_clr.
- If err_clr coincides with a new error event, the flag stays set.
- Threshold values above DEPTH are legal: almost_full then never asserts.

Optional Feature:
- Macro: FIFO_WATERMARK_EN.
- Defined: max_count registers the maximum data_count since reset or err_clr. It updates one cycle after the count changes, and err_clr loads the current data_count.
- Undefined: max_count tied to 0 and no watermark logic is generated.

Test Plan:
- Reset, then write 0x00001 at t → out_valid=1 and out_data=0x00001 at t+1; data_count=1; empty=0.
- With ADDR_WIDTH=4, write 16 words 0..15 with out_ready=0 → full=1, in_ready=0, data_count=16. A 17th write sets overflow_err. Reading back yields exactly 0..15, then empty=1.
- Continuous in_valid=out_ready=1 for 100 cycles with an incrementing pattern → output matches input order, one word per cycle, data_count stays constant.
- With af_thresh=12 and ae_thresh=3, fill from 0 to 16 → almost_empty=1 for counts 0..3, almost_full=1 for counts 12..16.
- out_ready=1 while empty → underflow_err=1. Pulse err_clr → both flags 0 the next cycle. Assert rst with 5 words held → empty=1, out_valid=0 the next cycle.
- With FIFO_WATERMARK_EN: fill to 9, drain to 2 → max_count=9. Pulse err_clr → max_count=2.
